ddr3_ui_responder: RTL and testbench

- Synthesizable responder for the DDR3 memory-controller user interface (UI): command port, write-data FIFO port and read-data return port. It stands in for the memory controller plus DRAM.
- Pipeline-side initiators (FIFO-to-DDR movers) connect to it unchanged, so they can be tested in simulation and on hardware without a physical DDR3 part.
- Storage is an internal block RAM of 256-bit UI words. Read data always returns in command order.

---
 rtl/ddr3_ui_responder.sv | 198 +++++++++++++++++++
 tb/tb_ddr3_ui_responder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_ui_responder.sv
// DDR3 user-interface responder: command FIFO, write-data FIFO and an in-order
// executor backed by an internal block RAM, returning reads after a fixed latency.
module ddr3_ui_responder #(
  parameter int unsigned DATA_W       = 256,
  parameter int unsigned ADDR_W       = 30,
  parameter int unsigned MEM_AW       = 10,
  parameter int unsigned ADDR_SHIFT   = 3,
  parameter int unsigned CMD_DEPTH    = 4,
  parameter int unsigned WDF_DEPTH    = 4,
  parameter int unsigned RD_LAT       = 4,
  parameter int unsigned CALIB_CYCLES = 64
) (
  input  logic                clk,
  input  logic                reset,
  output logic                calib_done,
  input  logic                rdy_stall,
  input  logic                app_en,
  input  logic [2:0]          app_cmd,
  input  logic [ADDR_W-1:0]   app_addr,
  output logic                app_rdy,
  input  logic                app_wdf_wren,
  input  logic [DATA_W-1:0]   app_wdf_data,
  input  logic                app_wdf_end,
  input  logic [DATA_W/8-1:0] app_wdf_mask,
  output logic                app_wdf_rdy,
  output logic [DATA_W-1:0]   app_rd_data,
  output logic                app_rd_data_valid,
  output logic                app_rd_data_end,
  output logic [31:0]         wr_done_cnt,
  output logic [31:0]         rd_done_cnt,
  output logic                err_sticky
);

  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned CMD_PW = $clog2(CMD_DEPTH);
  localparam int unsigned WDF_PW = $clog2(WDF_DEPTH);
  localparam int unsigned CMD_W  = 3 + MEM_AW;
  localparam int unsigned WDF_W  = DATA_W + MASK_W;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  typedef enum logic [0:0] {
    S_IDLE,
    S_WR_WAIT
  } state_t;

  state_t              state_q, state_d;
  logic                calib_done_q, calib_done_d;
  logic [31:0]         calib_cnt_q, calib_cnt_d;
  logic [CMD_PW:0]     cmd_wp_q, cmd_wp_d, cmd_rp_q, cmd_rp_d;
  logic [WDF_PW:0]     wdf_wp_q, wdf_wp_d, wdf_rp_q, wdf_rp_d;
  logic [RD_LAT-1:0]   vld_q, vld_d;
  logic [31:0]         wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic                err_q, err_d;

  logic [CMD_W-1:0]    cmd_mem [CMD_DEPTH];
  logic [WDF_W-1:0]    wdf_mem [WDF_DEPTH];
  logic [DATA_W-1:0]   mem     [2**MEM_AW];
  logic [DATA_W-1:0]   ram_rd_q;
  logic [DATA_W-1:0]   rdp_q   [RD_LAT-1];

  logic                cmd_empty, cmd_full, wdf_empty, wdf_full;
  logic                cmd_push, wdf_push;
  logic                do_write, do_read, do_drop, cmd_pop;
  logic [CMD_W-1:0]    head;
  logic [2:0]          head_cmd;
  logic [MEM_AW-1:0]   head_idx;
  logic [WDF_W-1:0]    wdf_head;
  logic [DATA_W-1:0]   wdf_head_data;
  logic [MASK_W-1:0]   wdf_head_mask;

  assign cmd_empty = (cmd_wp_q == cmd_rp_q);
  assign cmd_full  = (cmd_wp_q[CMD_PW] != cmd_rp_q[CMD_PW]) &&
                     (cmd_wp_q[CMD_PW-1:0] == cmd_rp_q[CMD_PW-1:0]);
  assign wdf_empty = (wdf_wp_q == wdf_rp_q);
  assign wdf_full  = (wdf_wp_q[WDF_PW] != wdf_rp_q[WDF_PW]) &&
                     (wdf_wp_q[WDF_PW-1:0] == wdf_rp_q[WDF_PW-1:0]);

  // Ready never looks past a full FIFO, even when the executor pops that cycle.
  assign app_rdy     = calib_done_q & ~rdy_stall & ~cmd_full;
  assign app_wdf_rdy = calib_done_q & ~rdy_stall & ~wdf_full;
  assign cmd_push    = app_en & app_rdy;
  assign wdf_push    = app_wdf_wren & app_wdf_rdy;

  assign head          = cmd_mem[cmd_rp_q[CMD_PW-1:0]];
  assign head_cmd      = head[CMD_W-1 -: 3];
  assign head_idx      = head[MEM_AW-1:0];
  assign wdf_head      = wdf_mem[wdf_rp_q[WDF_PW-1:0]];
  assign wdf_head_data = wdf_head[WDF_W-1 -: DATA_W];
  assign wdf_head_mask = wdf_head[MASK_W-1:0];

  always_comb begin
    state_d  = state_q;
    do_write = 1'b0;
    do_read  = 1'b0;
    do_drop  = 1'b0;
    // WR_WAIT always has a write at the head, so the write branch serves both states.
    if (!cmd_empty) begin
      if (head_cmd == CMD_WR) begin
        if (!wdf_empty) begin
          do_write = 1'b1;
          state_d  = S_IDLE;
        end else begin
          state_d  = S_WR_WAIT;
        end
      end else if (state_q == S_IDLE) begin
        if (head_cmd == CMD_RD) begin
          do_read = 1'b1;
        end else begin
          do_drop = 1'b1;
        end
      end
    end
  end

  assign cmd_pop = do_write | do_read | do_drop;

  always_comb begin
    calib_done_d = calib_done_q | (calib_cnt_q == 32'(CALIB_CYCLES - 1));
    calib_cnt_d  = calib_done_q ? calib_cnt_q : calib_cnt_q + 32'd1;
    cmd_wp_d     = cmd_wp_q + {{CMD_PW{1'b0}}, cmd_push};
    cmd_rp_d     = cmd_rp_q + {{CMD_PW{1'b0}}, cmd_pop};
    wdf_wp_d     = wdf_wp_q + {{WDF_PW{1'b0}}, wdf_push};
    wdf_rp_d     = wdf_rp_q + {{WDF_PW{1'b0}}, do_write};
    vld_d        = {vld_q[RD_LAT-2:0], do_read};
    wr_cnt_d     = wr_cnt_q + 32'(do_write);
    rd_cnt_d     = rd_cnt_q + 32'(vld_q[RD_LAT-2]);
    err_d        = err_q | do_drop | (wdf_push & ~app_wdf_end);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      calib_done_q <= 1'b0;
      calib_cnt_q  <= '0;
      cmd_wp_q     <= '0;
      cmd_rp_q     <= '0;
      wdf_wp_q     <= '0;
      wdf_rp_q     <= '0;
      vld_q        <= '0;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      err_q        <= 1'b0;
      for (int unsigned i = 0; i < RD_LAT - 1; i++) begin
        rdp_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      calib_done_q <= calib_done_d;
      calib_cnt_q  <= calib_cnt_d;
      cmd_wp_q     <= cmd_wp_d;
      cmd_rp_q     <= cmd_rp_d;
      wdf_wp_q     <= wdf_wp_d;
      wdf_rp_q     <= wdf_rp_d;
      vld_q        <= vld_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      err_q        <= err_d;
      rdp_q[0]     <= ram_rd_q;
      for (int unsigned i = 1; i < RD_LAT - 1; i++) begin
        rdp_q[i] <= rdp_q[i-1];
      end
    end
  end

  // Storage arrays carry no reset; only their pointers are cleared.
  always_ff @(posedge clk) begin
    if (cmd_push) begin
      cmd_mem[cmd_wp_q[CMD_PW-1:0]] <= {app_cmd, app_addr[ADDR_SHIFT +: MEM_AW]};
    end
    if (wdf_push) begin
      wdf_mem[wdf_wp_q[WDF_PW-1:0]] <= {app_wdf_data, app_wdf_mask};
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int unsigned b = 0; b < MASK_W; b++) begin
        if (!wdf_head_mask[b]) begin
          mem[head_idx][b*8 +: 8] <= wdf_head_data[b*8 +: 8];
        end
      end
    end
    if (do_read) begin
      ram_rd_q <= mem[head_idx];
    end
  end

  assign calib_done        = calib_done_q;
  assign app_rd_data       = rdp_q[RD_LAT-2];
  assign app_rd_data_valid = vld_q[RD_LAT-1];
  assign app_rd_data_end   = vld_q[RD_LAT-1];
  assign wr_done_cnt       = wr_cnt_q;
  assign rd_done_cnt       = rd_cnt_q;
  assign err_sticky        = err_q;

endmodule

// File: tb/tb_ddr3_ui_responder.sv
// Scoreboard bench for ddr3_ui_responder: expected read data is queued when a
// read is issued and compared when the DUT returns it.
module tb_ddr3_ui_responder;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         calib_done;
  logic         rdy_stall = 1'b0;
  logic         app_en = 1'b0;
  logic [2:0]   app_cmd = 3'b000;
  logic [29:0]  app_addr = '0;
  logic         app_rdy;
  logic         app_wdf_wren = 1'b0;
  logic [255:0] app_wdf_data = '0;
  logic         app_wdf_end = 1'b1;
  logic [31:0]  app_wdf_mask = '0;
  logic         app_wdf_rdy;
  logic [255:0] app_rd_data;
  logic         app_rd_data_valid;
  logic         app_rd_data_end;
  logic [31:0]  wr_done_cnt;
  logic [31:0]  rd_done_cnt;
  logic         err_sticky;

  ddr3_ui_responder #(
    .DATA_W(256), .ADDR_W(30), .MEM_AW(10), .ADDR_SHIFT(3),
    .CMD_DEPTH(4), .WDF_DEPTH(4), .RD_LAT(4), .CALIB_CYCLES(64)
  ) dut (
    .clk(clk), .reset(reset), .calib_done(calib_done), .rdy_stall(rdy_stall),
    .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
    .app_wdf_wren(app_wdf_wren), .app_wdf_data(app_wdf_data),
    .app_wdf_end(app_wdf_end), .app_wdf_mask(app_wdf_mask),
    .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
    .app_rd_data_valid(app_rd_data_valid), .app_rd_data_end(app_rd_data_end),
    .wr_done_cnt(wr_done_cnt), .rd_done_cnt(rd_done_cnt), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  int unsigned  n_checks = 0;
  int unsigned  n_pass   = 0;
  logic [255:0] sb [$];
  logic [255:0] ref_mem [int unsigned];
  int unsigned  exp_wr = 0;
  int unsigned  exp_rd = 0;
  logic         stall_en = 1'b0;
  int unsigned  stall_viol = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic int unsigned widx(input logic [29:0] a);
    return 32'((a >> 3) & 30'h3FF);
  endfunction

  always @(negedge clk) begin
    if (!reset && app_rd_data_valid) begin
      if (sb.size() == 0) begin
        check("rd_unexpected", 1, 0);
      end else begin
        check("rd_data", app_rd_data, sb.pop_front());
        check("rd_end", app_rd_data_end, 1);
      end
    end
    if (rdy_stall && (app_rdy || app_wdf_rdy)) stall_viol++;
  end

  initial begin
    int unsigned k = 0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_en) begin
        k++;
        if (k == 3) begin
          rdy_stall = ~rdy_stall;
          k = 0;
        end
      end
    end
  end

  task automatic send_cmd(input logic [2:0] c, input logic [29:0] a);
    int unsigned n = 0;
    @(negedge clk);
    app_en = 1'b1; app_cmd = c; app_addr = a;
    while (!app_rdy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("cmd_timeout", 1, 0);
    @(posedge clk);
    #1 app_en = 1'b0;
  endtask

  task automatic send_wdf(input logic [255:0] d, input logic [31:0] m);
    int unsigned n = 0;
    @(negedge clk);
    app_wdf_wren = 1'b1; app_wdf_data = d; app_wdf_mask = m; app_wdf_end = 1'b1;
    while (!app_wdf_rdy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("wdf_timeout", 1, 0);
    @(posedge clk);
    #1 app_wdf_wren = 1'b0;
  endtask

  function automatic void model_write(input logic [29:0] a, input logic [255:0] d,
                                      input logic [31:0] m);
    logic [255:0] old;
    int unsigned  i = widx(a);
    old = ref_mem.exists(i) ? ref_mem[i] : 'x;
    for (int b = 0; b < 32; b++) begin
      if (!m[b]) old[b*8 +: 8] = d[b*8 +: 8];
    end
    ref_mem[i] = old;
    exp_wr++;
  endfunction

  task automatic wr(input logic [29:0] a, input logic [255:0] d, input logic [31:0] m);
    model_write(a, d, m);
    fork
      send_cmd(3'b000, a);
      send_wdf(d, m);
    join
  endtask

  task automatic rd(input logic [29:0] a);
    sb.push_back(ref_mem[widx(a)]);
    exp_rd++;
    send_cmd(3'b001, a);
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (n >= 500) check("drain_timeout", 1, 0);
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic calibrate(input string tag);
    int unsigned cnt = 0;
    int unsigned early = 0;
    @(negedge clk);
    reset = 1'b0;
    while (!calib_done && cnt < 200) begin
      @(negedge clk);
      cnt++;
      if ((app_rdy || app_wdf_rdy) && cnt < 64) early++;
    end
    check({tag, "_cycles"}, cnt, 64);
    check({tag, "_early_rdy"}, early, 0);
  endtask

  initial begin
    int unsigned lat;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_calib", calib_done, 0);
    check("rst_rdy", {app_rdy, app_wdf_rdy}, 0);
    check("rst_valid", {app_rd_data_valid, app_rd_data_end}, 0);
    check("rst_rdata", app_rd_data, 0);
    check("rst_cnts", {wr_done_cnt, rd_done_cnt}, 0);
    check("rst_err", err_sticky, 0);

    // Calibration with a write held on both ports from reset release
    app_en = 1'b1; app_cmd = 3'b000; app_addr = 30'h10;
    app_wdf_wren = 1'b1; app_wdf_data = {32{8'hA5}}; app_wdf_mask = '0;
    model_write(30'h10, {32{8'hA5}}, '0);
    calibrate("calib");
    check("calib_rdy", {app_rdy, app_wdf_rdy}, 2'b11);
    @(posedge clk);
    #1 app_en = 1'b0; app_wdf_wren = 1'b0;

    // Write then read, with latency from acceptance (1 queue cycle + RD_LAT)
    rd(30'h10);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!app_rd_data_valid && lat < 50);
    check("rd_latency", lat, 5);
    drain();
    check("wr_cnt_1", wr_done_cnt, 1);
    check("rd_cnt_1", rd_done_cnt, 1);

    // Byte mask
    wr(30'h0, {32{8'hFF}}, '0);
    wr(30'h0, '0, 32'hFFFF_FFFE);
    rd(30'h0);
    drain();

    // Ordering under back-pressure
    stall_en = 1'b1;
    model_write(30'h40, {8{32'h1111_0001}}, '0);
    send_wdf({8{32'h1111_0001}}, '0);
    send_cmd(3'b000, 30'h40);
    model_write(30'h48, {8{32'h2222_0002}}, 32'h0000_00F0);
    send_cmd(3'b000, 30'h48);
    repeat (20) @(posedge clk);
    send_wdf({8{32'h2222_0002}}, 32'h0000_00F0);
    rd(30'h40);
    rd(30'h48);
    rd(30'h10);
    rd(30'h0);
    drain();
    stall_en = 1'b0;
    rdy_stall = 1'b0;
    check("stall_rdy_low", stall_viol, 0);
    check("wr_cnt_2", wr_done_cnt, exp_wr);
    check("rd_cnt_2", rd_done_cnt, exp_rd);

    // Address wrap and illegal command
    wr(30'h2000, {4{64'hDEAD_BEEF_0123_4567}}, '0);
    rd(30'h0);
    drain();
    check("err_clear", err_sticky, 0);
    send_cmd(3'b011, 30'h8);
    repeat (5) @(posedge clk);
    #1;
    check("err_set", err_sticky, 1);
    check("wr_cnt_3", wr_done_cnt, exp_wr);
    check("rd_cnt_3", rd_done_cnt, exp_rd);

    // Reset with reads in flight
    rd(30'h10);
    rd(30'h10);
    rd(30'h10);
    reset = 1'b1;
    sb.delete();
    #1;
    check("mid_rst_valid", app_rd_data_valid, 0);
    check("mid_rst_cnts", {wr_done_cnt, rd_done_cnt}, 0);
    check("mid_rst_err", err_sticky, 0);
    check("mid_rst_calib", calib_done, 0);
    repeat (3) @(posedge clk);
    calibrate("recal");
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_rd_cnt", rd_done_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
